unidade_controle_ula: RTL



---
 rtl/ula_pkg.sv | 40 ++++
 rtl/unidade_controle_ula_if.sv | 27 ++
 rtl/unidade_controle_ula_banco_registradores.sv | 34 +++
 rtl/unidade_controle_ula.sv | 108 ++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA control stage: opcodes, FSM states and instruction fields.
package ula_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int unsigned INSTR_W    = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExecute,
        StWriteback
    } state_e;

    // Bit 15 selects the format: 0 = ULA op, 1 = load immediate.
    localparam int unsigned KIND_BIT  = 15;
    localparam int unsigned OP_MSB    = 14;
    localparam int unsigned OP_LSB    = 12;
    localparam int unsigned RD_MSB    = 11;
    localparam int unsigned RD_LSB    = 9;
    localparam int unsigned RS1_MSB   = 8;
    localparam int unsigned RS1_LSB   = 6;
    localparam int unsigned RS2_MSB   = 5;
    localparam int unsigned RS2_LSB   = 3;
    localparam int unsigned LI_RD_MSB = 14;
    localparam int unsigned LI_RD_LSB = 12;
    localparam int unsigned IMM_MSB   = 11;
    localparam int unsigned IMM_W     = 12;

endpackage

// File: rtl/unidade_controle_ula_if.sv
// Instruction handshake, ULA operand/result bus and debug read port of the control stage.
interface unidade_controle_ula_if;

    logic                               instr_valid;
    logic [ula_pkg::INSTR_W-1:0]        instr;
    logic                               instr_ready;
    logic [ula_pkg::DATA_W-1:0]         operando1;
    logic [ula_pkg::DATA_W-1:0]         operando2;
    logic [2:0]                         opcode;
    logic [2*ula_pkg::DATA_W-1:0]       resultado;
    logic [ula_pkg::DATA_W-1:0]         hi;
    logic                               done;
    logic                               erro;
    logic [ula_pkg::REG_ADDR_W-1:0]     dbg_addr;
    logic [ula_pkg::DATA_W-1:0]         dbg_data;

    modport slave (
        input  instr_valid, instr, resultado, dbg_addr,
        output instr_ready, operando1, operando2, opcode, hi, done, erro, dbg_data
    );

    modport master (
        output instr_valid, instr, resultado, dbg_addr,
        input  instr_ready, operando1, operando2, opcode, hi, done, erro, dbg_data
    );

endinterface

// File: rtl/unidade_controle_ula_banco_registradores.sv
// 8x16 register bank: synchronous write, two combinational read ports plus a debug read port.
module banco_registradores
    import ula_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic [DATA_W-1:0]     dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/unidade_controle_ula.sv
// Multi-cycle control stage: decodes an instruction, feeds the ULA and writes its result back.
module unidade_controle_ula
    import ula_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    unidade_controle_ula_if.slave bus
);

    state_e                state;
    logic [INSTR_W-1:0]    instr_q;
    logic [2*DATA_W-1:0]   res_q;
    logic                  div_zero_q;
    logic [DATA_W-1:0]     operando1_q;
    logic [DATA_W-1:0]     operando2_q;
    logic [2:0]            opcode_q;
    logic [DATA_W-1:0]     hi_q;
    logic                  done_q;
    logic                  erro_q;

    logic                  is_li;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;

    assign is_li = instr_q[KIND_BIT];
    assign rd    = is_li ? instr_q[LI_RD_MSB:LI_RD_LSB] : instr_q[RD_MSB:RD_LSB];
    // A divide by zero still retires through writeback but must not touch the bank.
    assign we    = (state == StWriteback) && (is_li || !div_zero_q);
    assign wdata = is_li ? {{(DATA_W - IMM_W){1'b0}}, instr_q[IMM_MSB:0]} : res_q[DATA_W-1:0];

    banco_registradores u_banco (
        .clock    (clock),
        .reset    (reset),
        .we       (we),
        .waddr    (rd),
        .wdata    (wdata),
        .raddr1   (instr_q[RS1_MSB:RS1_LSB]),
        .raddr2   (instr_q[RS2_MSB:RS2_LSB]),
        .dbg_addr (bus.dbg_addr),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_data (bus.dbg_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            instr_q     <= '0;
            res_q       <= '0;
            div_zero_q  <= 1'b0;
            operando1_q <= '0;
            operando2_q <= '0;
            opcode_q    <= '0;
            hi_q        <= '0;
            done_q      <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state   <= StDecode;
                    end
                end
                StDecode: begin
                    if (is_li) begin
                        done_q <= 1'b1;
                        state  <= StWriteback;
                    end else begin
                        operando1_q <= rdata1;
                        operando2_q <= rdata2;
                        opcode_q    <= instr_q[OP_MSB:OP_LSB];
                        state       <= StExecute;
                    end
                end
                StExecute: begin
                    res_q      <= bus.resultado;
                    div_zero_q <= (opcode_q == OP_DIV) && (operando2_q == '0);
                    if ((opcode_q == OP_DIV) && (operando2_q == '0)) begin
                        erro_q <= 1'b1;
                    end
                    done_q <= 1'b1;
                    state  <= StWriteback;
                end
                StWriteback: begin
                    if (!is_li && !div_zero_q) begin
                        hi_q <= res_q[2*DATA_W-1:DATA_W];
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.instr_ready = (state == StIdle) && !reset;
    assign bus.operando1   = operando1_q;
    assign bus.operando2   = operando2_q;
    assign bus.opcode      = opcode_q;
    assign bus.hi          = hi_q;
    assign bus.done        = done_q;
    assign bus.erro        = erro_q;

endmodule
